// File: rtl/spi_input_conditioner.sv
// Conditions the three raw SPI pad inputs (sclk, cs, mosi): two-flop synchronizer,
// debounce counter and conditioned level per channel, plus registered edge pulses.
module spi_input_conditioner #(
   parameter int WAIT_TIME = 3,
   parameter int CNT_W     = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sclk_in,
   input  logic cs_in,
   input  logic mosi_in,
   output logic sclk_c,
   output logic cs_c,
   output logic mosi_c,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic cs_fall,
   output logic cs_rise,
   output logic mosi_bit
);

   // Channel index: 0 = sclk, 1 = cs, 2 = mosi.
   localparam int SCLK = 0;
   localparam int CS   = 1;
   localparam int MOSI = 2;
   localparam logic [2:0] IDLE = 3'b010;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_TIME - 1);

   logic [2:0]       raw;
   logic [2:0]       s0;
   logic [2:0]       s1;
   logic [2:0]       cond;
   logic [2:0]       rise;
   logic [2:0]       fall;
   logic [CNT_W-1:0] cnt [3];
   logic             sclk_accept;

   assign raw = {mosi_in, cs_in, sclk_in};

   // A rising sclk is accepted on this edge; mosi_bit takes the pre-edge mosi level.
   assign sclk_accept = s1[SCLK] && !cond[SCLK] && (cnt[SCLK] == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0       <= IDLE;
         s1       <= IDLE;
         cond     <= IDLE;
         rise     <= '0;
         fall     <= '0;
         mosi_bit <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         s0   <= raw;
         s1   <= s0;
         rise <= '0;
         fall <= '0;
         for (int i = 0; i < 3; i++) begin
            if (s1[i] == cond[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == LAST) begin
               cond[i] <= s1[i];
               cnt[i]  <= '0;
               rise[i] <= s1[i];
               fall[i] <= ~s1[i];
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
         if (sclk_accept) begin
            mosi_bit <= cond[MOSI];
         end
      end
   end

   assign sclk_c    = cond[SCLK];
   assign cs_c      = cond[CS];
   assign mosi_c    = cond[MOSI];
   assign sclk_rise = rise[SCLK];
   assign sclk_fall = fall[SCLK];
   assign cs_rise   = rise[CS];
   assign cs_fall   = fall[CS];

endmodule
